mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the IF fetch path and the MEM stage load/store path (the path fed by the EX/MEM pipeline register).
- Arbitrates between the two requesters and sequences a req/ack transaction to memory.
- Returns the read data and a one-cycle ready pulse to the winning requester.
- Drives the global pipeline stall while either requester is waiting.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, maximum cycles to wait for ram_ack_i; 0 disables the timeout.
- STARVE_LIMIT, 4, consecutive MEM grants allowed while IF waits (used only with STARVE_GUARD_EN).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-low
- if_req_i  in  1  fetch request, held high until if_ready_o
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetched word, registered
- if_ready_o  out  1  one-cycle completion pulse for IF
- mem_req_i  in  1  load/store request (MemRead|MemWrite), held until mem_ready_o
- mem_we_i  in  1  1 = store
- mem_addr_i  in  ADDR_W  load/store address (ALU result)
- mem_wdata_i  in  DATA_W  store data
- mem_rdata_o  out  DATA_W  load data, registered
- mem_ready_o  out  1  one-cycle completion pulse for MEM
- stall_o  out  1  pipeline stall
- ram_req_o  out  1  memory request, held until ack
- ram_we_o  out  1  memory write enable
- ram_addr_o  out  ADDR_W  memory address
- ram_wdata_o  out  DATA_W  memory write data
- ram_rdata_i  in  DATA_W  memory read data, valid with ram_ack_i
- ram_ack_i  in  1  one-cycle completion from memory
- err_o  out  1  sticky timeout flag

Behaviour:
- Reset: every output is 0, state is IDLE, counters are 0. Reset mid-transaction abandons the access: ram_req_o drops immediately and no ready pulse is issued.
- FSM states: IDLE, BUSY, RESP.
- IDLE arbitration:
  - mem_req_i=1: grant MEM (the older instruction has priority).
  - Otherwise if_req_i=1: grant IF.
  - Otherwise stay in IDLE.
- On grant: latch owner, addr, we and wdata into the ram_* registers; set ram_req_o=1 on the next cycle; enter BUSY. IF grants always have ram_we_o=0.
- BUSY:
  - ram_* outputs are held stable.
  - On ram_ack_i: ram_req_o goes 0 next cycle; a read captures ram_rdata_i into the owner's rdata_o; enter RESP.
  - A store leaves mem_rdata_o unchanged.
  - ram_ack_i may arrive in the same cycle ram_req_o first goes high.
- RESP: owner's ready_o=1 for exactly this cycle; no arbitration; next state IDLE.
- Minimum latency: request sampled in cycle 0, ram_req_o high in cycle 1, ack in cycle 1, ready_o in cycle 2. The next grant can occur in cycle 3.
- ram_ack_i received in IDLE or RESP is ignored.
- Timeout (TIMEOUT>0):
  - Counter starts at 0 when BUSY is entered and increments each cycle.
  - Reaching TIMEOUT without ack: drop ram_req_o, set err_o=1, enter RESP. The owner's rdata_o is written with 0 for a read.
  - If ack and timeout coincide, the ack wins and err_o is not set.
  - err_o is cleared only by reset.
- stall_o (combinational) = (mem_req_i & ~mem_ready_o) | (if_req_i & ~if_ready_o).
- rdata_o registers hold their value until the next completion for that owner.

Optional Feature:
- STARVE_GUARD_EN defined:
  - A counter tracks consecutive MEM grants made while if_req_i=1.
  - When the counter reaches STARVE_LIMIT and both requests are pending in IDLE, IF is granted and the counter resets.
  - The counter also resets on any IF grant, and on any MEM grant made while if_req_i=0.
- STARVE_GUARD_EN undefined: fixed MEM priority, no counter logic.

Test Plan:
- Reset mid-BUSY (rst_i low while ram_req_o=1) -> all outputs 0 asynchronously; after release, no ready pulse; next request is serviced normally.
- IF read, addr 0x40, ack in the same cycle ram_req_o rises with rdata 0x00000013 -> ram_addr_o=0x40 and ram_we_o=0 in cycle 1; if_ready_o=1 in cycle 2; if_rdata_o=0x00000013.
- if_req_i and mem_req_i (store, addr 0x100, wdata 0xCAFEF00D) rise together, ack after 3 cycles -> MEM granted first with ram_we_o=1 and ram_wdata_o=0xCAFEF00D; mem_ready_o pulses; IF is granted in the following IDLE; stall_o stays high throughout.
- MEM load with TIMEOUT=8 and no ack -> ram_req_o drops after 8 BUSY cycles; mem_ready_o pulses; mem_rdata_o=0; err_o=1 and stays 1.
- Stray ram_ack_i in IDLE with rdata 0xFFFFFFFF -> no ready pulse; rdata_o registers unchanged.
- STARVE_GUARD_EN, STARVE_LIMIT=4, mem_req_i and if_req_i held high continuously -> grant order MEM, MEM, MEM, MEM, IF, MEM, ...

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory between IF fetch and MEM load/store.
// Define STARVE_GUARD_EN to force an IF grant after STARVE_LIMIT back-to-back MEM grants.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 255,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ready_o,
    output logic              stall_o,
    output logic              ram_req_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    input  logic              ram_ack_i,
    output logic              err_o
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    state_t state;
    logic owner;
    logic [CW-1:0] toCnt;
    logic starveForce, grantMem, timedOut;
    logic [DATA_W-1:0] rdVal;
    assign grantMem = mem_req_i && !starveForce;
    assign timedOut = (TIMEOUT > 0) && (toCnt == CW'(TIMEOUT - 1));
    assign rdVal    = ram_ack_i ? ram_rdata_i : '0;
    assign stall_o  = (mem_req_i & ~mem_ready_o) | (if_req_i & ~if_ready_o);
`ifdef STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starveCnt;
    assign starveForce = if_req_i && mem_req_i && (starveCnt >= SW'(STARVE_LIMIT));
    // Counts only MEM grants that left a pending fetch behind.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            starveCnt <= '0;
        else if (state == IDLE && (mem_req_i || if_req_i))
            starveCnt <= (grantMem && if_req_i) ? starveCnt + 1'b1 : '0;
    end
`else
    assign starveForce = 1'b0;
`endif
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            owner       <= 1'b0;
            toCnt       <= '0;
            ram_req_o   <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            if_rdata_o  <= '0;
            mem_rdata_o <= '0;
            if_ready_o  <= 1'b0;
            mem_ready_o <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (grantMem || if_req_i) begin
                    owner       <= grantMem;
                    ram_req_o   <= 1'b1;
                    ram_we_o    <= grantMem & mem_we_i;
                    ram_addr_o  <= grantMem ? mem_addr_i : if_addr_i;
                    ram_wdata_o <= grantMem ? mem_wdata_i : '0;
                    toCnt       <= '0;
                    state       <= BUSY;
                end
                BUSY: if (ram_ack_i || timedOut) begin
                    // An ack coinciding with the timeout wins; a timed-out read returns 0.
                    ram_req_o   <= 1'b0;
                    if (!ram_we_o && owner)  mem_rdata_o <= rdVal;
                    if (!ram_we_o && !owner) if_rdata_o  <= rdVal;
                    mem_ready_o <= owner;
                    if_ready_o  <= !owner;
                    err_o       <= err_o | !ram_ack_i;
                    state       <= RESP;
                end else begin
                    toCnt <= toCnt + 1'b1;
                end
                default: begin
                    mem_ready_o <= 1'b0;
                    if_ready_o  <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table plus hand-written multi-cycle sequences.
module tb_mem_port_arbiter;
    logic clk = 1'b0, rst = 1'b0;
    logic ifReq = 0, memReq = 0, memWe = 0, ramAck = 0;
    logic [31:0] ifAddr = 0, memAddr = 0, memWdata = 0, ramRdata = 0;
    logic [31:0] ifRdata, memRdata, ramAddr, ramWdata;
    logic ifReady, memReady, stall, ramReq, ramWe, err;
    int total = 0, bad = 0;
    logic [31:0] expIf = 0, expMem = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .STARVE_LIMIT(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(ifReq), .if_addr_i(ifAddr), .if_rdata_o(ifRdata), .if_ready_o(ifReady),
        .mem_req_i(memReq), .mem_we_i(memWe), .mem_addr_i(memAddr), .mem_wdata_i(memWdata),
        .mem_rdata_o(memRdata), .mem_ready_o(memReady), .stall_o(stall),
        .ram_req_o(ramReq), .ram_we_o(ramWe), .ram_addr_o(ramAddr), .ram_wdata_o(ramWdata),
        .ram_rdata_i(ramRdata), .ram_ack_i(ramAck), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        isMem;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        logic [31:0] expRdata;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkIdleOuts(input string name);
        chk({name, " ram_req"}, ramReq, 0);
        chk({name, " if_ready"}, ifReady, 0);
        chk({name, " mem_ready"}, memReady, 0);
    endtask

    // One full transaction; request is raised at a negedge, granted on the next posedge.
    task automatic doTxn(input vec_t v);
        ifReq = !v.isMem; ifAddr = v.addr;
        memReq = v.isMem; memWe = v.we; memAddr = v.addr; memWdata = v.wdata;
        @(negedge clk);
        chk("grant ram_req", ramReq, 1);
        chk("grant ram_addr", ramAddr, v.addr);
        chk("grant ram_we", ramWe, v.we);
        if (v.we) chk("grant ram_wdata", ramWdata, v.wdata);
        chk("busy stall", stall, 1);
        repeat (v.delay) begin
            @(negedge clk);
            chk("busy hold req", ramReq, 1);
        end
        ramAck = 1; ramRdata = v.rdata;
        @(negedge clk);
        ramAck = 0;
        chk("resp if_ready", ifReady, !v.isMem);
        chk("resp mem_ready", memReady, v.isMem);
        chk("resp ram_req", ramReq, 0);
        if (v.isMem) chk("mem_rdata", memRdata, v.expRdata);
        else         chk("if_rdata", ifRdata, v.expRdata);
        chk("resp stall", stall, 0);
        ifReq = 0; memReq = 0; memWe = 0;
        @(negedge clk);
        chkIdleOuts("after resp");
        if (v.isMem) expMem = v.expRdata; else expIf = v.expRdata;
    endtask

    initial begin
        vecs[0] = '{0, 0, 32'h40, 32'h0,        0, 32'h00000013, 32'h00000013};
        vecs[1] = '{1, 0, 32'h80, 32'h0,        2, 32'h11223344, 32'h11223344};
        vecs[2] = '{1, 1, 32'h84, 32'hDEADBEEF, 1, 32'h55555555, 32'h11223344};
        vecs[3] = '{0, 0, 32'h44, 32'h0,        4, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[4] = '{1, 0, 32'h88, 32'h0,        0, 32'h0BADF00D, 32'h0BADF00D};

        repeat (2) @(negedge clk);
        chkIdleOuts("reset");
        chk("reset err", err, 0);
        chk("reset rdata", {ifRdata, memRdata}, 0);
        rst = 1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) doTxn(vecs[i]);

        // Simultaneous requests: MEM store first, IF next, stall high throughout.
        ifReq = 1; ifAddr = 32'h48;
        memReq = 1; memWe = 1; memAddr = 32'h100; memWdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("both ram_we", ramWe, 1);
        chk("both ram_addr", ramAddr, 32'h100);
        chk("both ram_wdata", ramWdata, 32'hCAFEF00D);
        repeat (3) begin
            chk("both stall", stall, 1);
            @(negedge clk);
        end
        ramAck = 1; ramRdata = 32'h77777777;
        @(negedge clk);
        ramAck = 0;
        chk("both mem_ready", memReady, 1);
        chk("both if_ready", ifReady, 0);
        chk("both stall resp", stall, 1);
        chk("store keeps mem_rdata", memRdata, expMem);
        memReq = 0; memWe = 0;
        @(negedge clk);
        chk("both stall idle", stall, 1);
        @(negedge clk);
        chk("if grant ram_req", ramReq, 1);
        chk("if grant ram_addr", ramAddr, 32'h48);
        chk("if grant ram_we", ramWe, 0);
        ramAck = 1; ramRdata = 32'h12345678;
        @(negedge clk);
        ramAck = 0;
        chk("if grant ready", ifReady, 1);
        chk("if grant rdata", ifRdata, 32'h12345678);
        expIf = 32'h12345678;
        ifReq = 0;
        @(negedge clk);

        // Stray ack in IDLE is ignored.
        ramAck = 1; ramRdata = 32'hFFFFFFFF;
        @(negedge clk);
        ramAck = 0;
        @(negedge clk);
        chkIdleOuts("stray");
        chk("stray if_rdata", ifRdata, expIf);
        chk("stray mem_rdata", memRdata, expMem);

        // Timeout: MEM load never acked, req high for exactly 8 BUSY cycles.
        memReq = 1; memAddr = 32'h90;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("timeout req held", ramReq, 1);
        end
        @(negedge clk);
        chk("timeout req drop", ramReq, 0);
        chk("timeout mem_ready", memReady, 1);
        chk("timeout mem_rdata", memRdata, 0);
        chk("timeout err", err, 1);
        expMem = 0;
        memReq = 0;
        @(negedge clk);
        doTxn('{0, 0, 32'h4C, 32'h0, 1, 32'h0000BEEF, 32'h0000BEEF});
        chk("err sticky", err, 1);

        // Reset mid-BUSY clears outputs asynchronously and abandons the access.
        ifReq = 1; ifAddr = 32'h50;
        @(negedge clk);
        chk("pre-reset ram_req", ramReq, 1);
        #2 rst = 0;
        #1;
        chkIdleOuts("async reset");
        chk("async reset err", err, 0);
        chk("async reset rdata", {ifRdata, memRdata}, 0);
        ifReq = 0;
        @(negedge clk);
        rst = 1;
        repeat (2) begin
            @(negedge clk);
            chkIdleOuts("post reset");
        end
        expIf = 0; expMem = 0;
        doTxn('{0, 0, 32'h54, 32'h0, 0, 32'h00C0FFEE, 32'h00C0FFEE});

        // Both requests held continuously: grant order check.
        ifReq = 1; ifAddr = 32'h300;
        memReq = 1; memWe = 0; memAddr = 32'h200;
        for (int g = 0; g < 6; g++) begin
            automatic int waitN = 0;
            automatic logic [31:0] want = 32'h200;
`ifdef STARVE_GUARD_EN
            if (g == 4) want = 32'h300;
`endif
            @(negedge clk);
            while (!ramReq && waitN < 10) begin
                @(negedge clk);
                waitN++;
            end
            if (waitN >= 10) chk("prio wait timeout", 1, 0);
            chk($sformatf("prio grant %0d", g), ramAddr, want);
            ramAck = 1; ramRdata = 32'h0;
            @(negedge clk);
            ramAck = 0;
        end
        ifReq = 0; memReq = 0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
